lbuf_ram_arb: RTL and testbench
===============================

// Module: lbuf_ram_arb
// PURPOSE
//  Sequencer/arbiter for one 512x16 single-port synchronous RAM macro (cen/rw/a[0:8]/z_in/z_out/z_oe).
//  Shares the RAM between two requesters, port A (CPU/bus side) and port B (object/pixel side).
//  Optionally zero-fills the RAM after reset, then grants at most one access per sys_clk.
//  Returns read data on the owning port with fixed 1-cycle latency.
// PARAMETERS
//  PRIO_FIXED      0       1: port A always wins a conflict; 0: round-robin between A and B
//  CLEAR_ON_RESET  1       1: walk all 512 words writing CLEAR_VALUE after reset; 0: go straight to RUN
//  CLEAR_VALUE     16'h0   data written during the clear walk
// PORTS
//  sys_clk      in   1       single clock; all state changes on posedge
//  resetl       in   1       synchronous reset, active low
//  a_req        in   1       port A request; hold a_rw/a_addr/a_wdata stable until a_ack
//  a_rw         in   1       1 = read, 0 = write
//  a_addr       in   9       word address, bit 0 = LSB
//  a_wdata      in   16      write data
//  a_ack        out  1       request granted this cycle (combinational)
//  a_rdata      out  16      read data, valid when a_rvalid
//  a_rvalid     out  1       one-cycle strobe, cycle after a granted read
//  b_*          --   --      identical set for port B (b_req, b_rw, b_addr, b_wdata, b_ack, b_rdata, b_rvalid)
//  ram_cen      out  1       RAM chip enable, active low
//  ram_rw       out  1       RAM 1 = read, 0 = write
//  ram_a        out  [0:8]   RAM address, ram_a[n] = address bit n
//  ram_z_in     out  [0:15]  RAM write data, ram_z_in[n] = data bit n
//  ram_z_out    in   [0:15]  RAM registered read data
//  ram_z_oe     in   [0:15]  RAM output-enable, all-ones the cycle read data is valid
//  clear_done   out  1       high once state = RUN
// BEHAVIOUR
//  States: CLEAR, RUN. Reset: CLEAR if CLEAR_ON_RESET, else RUN; clear counter = 0;
//   rr pointer = A; rd_pend = 0; rd_owner = A; a/b_rvalid = 0; clear_done = 0.
//  While resetl low: ram_cen = 1, a_ack = b_ack = 0; these override all logic.
//  CLEAR: each cycle ram_cen = 0, ram_rw = 0, ram_a = counter, ram_z_in = CLEAR_VALUE; acks stay 0.
//   Counter increments every cycle; after the write at 511 -> RUN (512 cycles in CLEAR).
//   Counter wraps 511 -> 0; the wrap is never used.
//  RUN: grant = A if a_req & (~b_req | PRIO_FIXED | rr == A); B if b_req & not granted A.
//   Granted port: ack = 1 same cycle; ram_cen = 0, ram_rw/ram_a/ram_z_in from that port.
//   No grant: ram_cen = 1, ram_rw = 1, ram_a and ram_z_in hold the last driven values.
//  rr update: only when a_req & b_req; rr <= the port not granted. Single requests leave rr unchanged.
//  Read return:
//   - granted read sets rd_pend <= 1 and rd_owner <= port; otherwise rd_pend <= 0.
//   - x_rvalid = rd_pend & (rd_owner == x) & (&ram_z_oe), registered-aligned to the RAM output cycle.
//   - x_rdata = ram_z_out (bit-reversed to [15:0]) in that cycle; holds last value otherwise.
//   - ram_z_oe not all-ones while rd_pend = 1 is a RAM fault; drop rvalid and flag it with an assertion.
//  Throughput: one access per cycle, back-to-back legal. Write N then read N next cycle returns new data.
//  Both ports at the same address same cycle: only one is granted; the other waits (no merging).
//  Reset mid-CLEAR or mid-read: pending rvalid suppressed; CLEAR restarts at address 0.
// STRUCTURE
//  Package lbuf_ram_arb_pkg: ADDR_W = 9, DATA_W = 16, RAM_WORDS = 512, state enum {CLEAR, RUN}, port id enum {PORT_A, PORT_B}.
//  One sub-module, rr_arb2: 2-way grant + rr pointer with PRIO_FIXED, reused elsewhere.
//  Top level keeps the CLEAR FSM, read-return tag pipe and RAM bit-order mapping.
// TESTING
//  Reset, CLEAR_ON_RESET=1: 512 writes of 0 at addr 0..511, then clear_done = 1 at cycle 512; no acks before.
//  A writes 0x1234 to 0x005, then reads 0x005: a_ack on both; a_rvalid 1 cycle after read grant; a_rdata = 0x1234; b_rvalid = 0.
//  A and B request reads every cycle, rr mode: grants alternate A,B,A,B; each rvalid on the correct port with its own data.
//  PRIO_FIXED=1, both requesting continuously: B never acked until a_req drops; then B acked the same cycle.
//  resetl low during CLEAR at counter 200: CLEAR restarts at 0; total 512 more cycles to clear_done.
//  resetl low the cycle after a granted read: no rvalid; ram_cen = 1 throughout reset.

Source files
------------

// File: rtl/lbuf_ram_arb_pkg.sv
// Shared widths and enums for the line-buffer RAM arbiter.
// Imported by the top level and by the reusable 2-way arbiter.
package lbuf_ram_arb_pkg;
   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 16;
   localparam int RAM_WORDS = 512;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;
   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

// File: rtl/lbuf_ram_arb_rr_arb2.sv
// Two-way arbiter: combinational grant with either fixed A priority or a
// round-robin pointer that only moves when both sides contend.
module rr_arb2
   import lbuf_ram_arb_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic clk,
   input  logic resetl,
   input  logic en,
   input  logic a_req,
   input  logic b_req,
   output logic gnt_a,
   output logic gnt_b
);
   port_e rr_r;

   // grant decision
   always_comb begin
      gnt_a = a_req & (~b_req | PRIO_FIXED | (rr_r == PORT_A));
      gnt_b = b_req & ~gnt_a;
   end

   // pointer hands the next conflict to whichever side lost this one
   always_ff @(posedge clk) begin
      if (!resetl) begin
         rr_r <= PORT_A;
      end else if (en && a_req && b_req) begin
         rr_r <= gnt_a ? PORT_B : PORT_A;
      end else begin
         rr_r <= rr_r;
      end
   end
endmodule

// File: rtl/lbuf_ram_arb.sv
// Sequencer/arbiter sharing one 512x16 single-port RAM between ports A and B,
// with optional post-reset zero-fill and 1-cycle read return.
module lbuf_ram_arb
   import lbuf_ram_arb_pkg::*;
#(
   parameter bit                PRIO_FIXED     = 1'b0,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = 16'h0000
) (
   input  logic              sys_clk,
   input  logic              resetl,
   input  logic              a_req,
   input  logic              a_rw,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_rw,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic              ram_cen,
   output logic              ram_rw,
   output logic [0:ADDR_W-1] ram_a,
   output logic [0:DATA_W-1] ram_z_in,
   input  logic [0:DATA_W-1] ram_z_out,
   input  logic [0:DATA_W-1] ram_z_oe,
   output logic              clear_done
);
   state_e            state_r, state_nxt;
   logic [ADDR_W-1:0] cnt_r, cnt_nxt;
   logic              done_r;
   logic              arb_a_s, arb_b_s, run_s, clr_s, gnt_a_s, gnt_b_s;
   logic              cen_s, rw_s;
   logic [ADDR_W-1:0] addr_s, last_addr_r;
   logic [DATA_W-1:0] wd_s, last_wd_r, zrev_s, a_hold_r, b_hold_r;
   logic              rd_pend_r;
   port_e             rd_owner_r;

   assign run_s   = resetl & (state_r == RUN);
   assign clr_s   = resetl & (state_r == CLEAR);
   assign gnt_a_s = run_s & arb_a_s;
   assign gnt_b_s = run_s & arb_b_s;

   rr_arb2 #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
      .clk    (sys_clk),
      .resetl (resetl),
      .en     (run_s),
      .a_req  (a_req),
      .b_req  (b_req),
      .gnt_a  (arb_a_s),
      .gnt_b  (arb_b_s)
   );

   // clear walk: one write per cycle, leave after the last word
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      case (state_r)
         CLEAR: begin
            cnt_nxt = cnt_r + 9'd1;
            if (cnt_r == ADDR_W'(RAM_WORDS - 1)) begin
               state_nxt = RUN;
            end else begin
               state_nxt = CLEAR;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // state, counter and done flag
   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         state_r <= CLEAR_ON_RESET ? CLEAR : RUN;
         cnt_r   <= 9'd0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         done_r  <= (state_nxt == RUN);
      end
   end

   // RAM command mux; idle cycles keep the last address/data on the pins
   always_comb begin
      cen_s  = 1'b1;
      rw_s   = 1'b1;
      addr_s = last_addr_r;
      wd_s   = last_wd_r;
      if (clr_s) begin
         cen_s  = 1'b0;
         rw_s   = 1'b0;
         addr_s = cnt_r;
         wd_s   = CLEAR_VALUE;
      end else if (gnt_a_s) begin
         cen_s  = 1'b0;
         rw_s   = a_rw;
         addr_s = a_addr;
         wd_s   = a_wdata;
      end else if (gnt_b_s) begin
         cen_s  = 1'b0;
         rw_s   = b_rw;
         addr_s = b_addr;
         wd_s   = b_wdata;
      end else begin
         cen_s  = 1'b1;
      end
   end

   // RAM buses are ascending-indexed: bit n on the pin is bit n of the value
   always_comb begin
      for (int n = 0; n < ADDR_W; n++) ram_a[n] = addr_s[n];
      for (int n = 0; n < DATA_W; n++) ram_z_in[n] = wd_s[n];
      for (int n = 0; n < DATA_W; n++) zrev_s[n] = ram_z_out[n];
   end

   assign ram_cen    = cen_s;
   assign ram_rw     = rw_s;
   assign a_ack      = gnt_a_s;
   assign b_ack      = gnt_b_s;
   assign clear_done = done_r;
   assign a_rvalid   = resetl & rd_pend_r & (rd_owner_r == PORT_A) & (&ram_z_oe);
   assign b_rvalid   = resetl & rd_pend_r & (rd_owner_r == PORT_B) & (&ram_z_oe);
   assign a_rdata    = a_rvalid ? zrev_s : a_hold_r;
   assign b_rdata    = b_rvalid ? zrev_s : b_hold_r;

   // read-return tag, pin hold values and per-port read data hold
   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         rd_pend_r   <= 1'b0;
         rd_owner_r  <= PORT_A;
         last_addr_r <= 9'd0;
         last_wd_r   <= 16'h0000;
         a_hold_r    <= 16'h0000;
         b_hold_r    <= 16'h0000;
      end else begin
         rd_pend_r   <= (gnt_a_s & a_rw) | (gnt_b_s & b_rw);
         if (gnt_a_s && a_rw) begin
            rd_owner_r <= PORT_A;
         end else if (gnt_b_s && b_rw) begin
            rd_owner_r <= PORT_B;
         end else begin
            rd_owner_r <= rd_owner_r;
         end
         last_addr_r <= addr_s;
         last_wd_r   <= wd_s;
         a_hold_r    <= a_rdata;
         b_hold_r    <= b_rdata;
      end
   end

   rd_oe_fault: assert property (@(posedge sys_clk) disable iff (!resetl)
      rd_pend_r |-> (&ram_z_oe));
endmodule

// File: tb/tb_lbuf_ram_arb.sv
// Randomized bench for lbuf_ram_arb against a queue/array-level reference
// model; a second PRIO_FIXED instance shares the request inputs.
module tb_lbuf_ram_arb;
   logic        clk = 1'b0;
   logic        resetl;
   logic        a_req, a_rw, b_req, b_rw;
   logic [8:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic        a_ack, b_ack, a_rvalid, b_rvalid, ram_cen, ram_rw, clear_done;
   logic [0:8]  ram_a;
   logic [0:15] ram_z_in;
   logic [0:15] ram_z_out = '0;
   logic [0:15] ram_z_oe  = '0;

   logic        p_a_ack, p_b_ack, p_a_rvalid, p_b_rvalid, p_cen, p_rw, p_done;
   logic [15:0] p_a_rdata, p_b_rdata;
   logic [0:8]  p_ram_a;
   logic [0:15] p_z_in;
   logic [0:15] p_z_out = '0;
   logic [0:15] p_z_oe  = '1;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [15:0] ref_mem [0:511];
   bit          m_clear = 1'b1;
   int          m_cnt = 0;
   bit          m_rr_a = 1'b1;
   bit          m_pend = 1'b0;
   bit          m_owner_a = 1'b1;
   logic [15:0] m_pdata = 16'h0000;
   bit          a_got = 1'b0, b_got = 1'b0;

   logic [15:0] mem [0:511];

   always #5 clk = ~clk;

   lbuf_ram_arb dut (
      .sys_clk(clk), .resetl(resetl),
      .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .ram_cen(ram_cen), .ram_rw(ram_rw), .ram_a(ram_a), .ram_z_in(ram_z_in),
      .ram_z_out(ram_z_out), .ram_z_oe(ram_z_oe), .clear_done(clear_done)
   );

   lbuf_ram_arb #(.PRIO_FIXED(1'b1), .CLEAR_ON_RESET(1'b0)) dut_p (
      .sys_clk(clk), .resetl(resetl),
      .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(p_a_ack), .a_rdata(p_a_rdata), .a_rvalid(p_a_rvalid),
      .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(p_b_ack), .b_rdata(p_b_rdata), .b_rvalid(p_b_rvalid),
      .ram_cen(p_cen), .ram_rw(p_rw), .ram_a(p_ram_a), .ram_z_in(p_z_in),
      .ram_z_out(p_z_out), .ram_z_oe(p_z_oe), .clear_done(p_done)
   );

   function automatic logic [8:0] a2i(input logic [0:8] v);
      logic [8:0] r;
      for (int n = 0; n < 9; n++) r[n] = v[n];
      return r;
   endfunction

   function automatic logic [15:0] d2i(input logic [0:15] v);
      logic [15:0] r;
      for (int n = 0; n < 16; n++) r[n] = v[n];
      return r;
   endfunction

   function automatic logic [0:15] i2d(input logic [15:0] v);
      logic [0:15] r;
      for (int n = 0; n < 16; n++) r[n] = v[n];
      return r;
   endfunction

   // behavioural single-port RAM with registered read data
   always @(posedge clk) begin
      if (!ram_cen && ram_rw) begin
         ram_z_out <= i2d(mem[a2i(ram_a)]);
         ram_z_oe  <= '1;
      end else begin
         if (!ram_cen) mem[a2i(ram_a)] <= d2i(ram_z_in);
         ram_z_oe <= '0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock: check at negedge, advance the model at posedge
   task automatic cycle();
      bit ga, gb, ecen;
      @(negedge clk);
      ga = 1'b0;
      gb = 1'b0;
      if (resetl && !m_clear) begin
         ga = a_req && (!b_req || m_rr_a);
         gb = b_req && !ga;
      end
      ecen = !(resetl && (m_clear || ga || gb));
      check_val("a_ack", a_ack, ga);
      check_val("b_ack", b_ack, gb);
      check_val("ram_cen", ram_cen, ecen);
      if (resetl && m_clear) begin
         check_val("clr_rw", ram_rw, 1'b0);
         check_val("clr_addr", a2i(ram_a), m_cnt);
         check_val("clr_data", d2i(ram_z_in), 16'h0000);
      end
      if (ga || gb) begin
         check_val("ram_rw", ram_rw, ga ? a_rw : b_rw);
         check_val("ram_a", a2i(ram_a), ga ? a_addr : b_addr);
         if (!(ga ? a_rw : b_rw)) check_val("ram_z_in", d2i(ram_z_in), ga ? a_wdata : b_wdata);
      end
      check_val("a_rvalid", a_rvalid, resetl && m_pend && m_owner_a);
      check_val("b_rvalid", b_rvalid, resetl && m_pend && !m_owner_a);
      if (resetl && m_pend && m_owner_a) check_val("a_rdata", a_rdata, m_pdata);
      if (resetl && m_pend && !m_owner_a) check_val("b_rdata", b_rdata, m_pdata);
      check_val("clear_done", clear_done, !m_clear);
      check_val("prio_a_ack", p_a_ack, resetl && a_req);
      check_val("prio_b_ack", p_b_ack, resetl && b_req && !a_req);
      a_got = ga;
      b_got = gb;
      @(posedge clk);
      m_pend = 1'b0;
      if (!resetl) begin
         m_clear = 1'b1;
         m_cnt   = 0;
         m_rr_a  = 1'b1;
      end else if (m_clear) begin
         ref_mem[m_cnt] = 16'h0000;
         m_cnt++;
         if (m_cnt == 512) m_clear = 1'b0;
      end else begin
         if (ga) begin
            if (a_rw) begin
               m_pend = 1'b1; m_owner_a = 1'b1; m_pdata = ref_mem[a_addr];
            end else ref_mem[a_addr] = a_wdata;
         end
         if (gb) begin
            if (b_rw) begin
               m_pend = 1'b1; m_owner_a = 1'b0; m_pdata = ref_mem[b_addr];
            end else ref_mem[b_addr] = b_wdata;
         end
         if (a_req && b_req) m_rr_a = gb;
      end
      #1;
   endtask

   // new request on a port once the previous one was accepted
   task automatic rand_cycles(input int ncyc, input int pct, input bit rd_only);
      for (int i = 0; i < ncyc; i++) begin
         if (!a_req || a_got) begin
            a_req = ($urandom_range(99) < pct);
            a_rw = rd_only ? 1'b1 : 1'($urandom_range(1));
            a_addr = 9'($urandom_range(15)); a_wdata = 16'($urandom);
         end
         if (!b_req || b_got) begin
            b_req = ($urandom_range(99) < pct);
            b_rw = rd_only ? 1'b1 : 1'($urandom_range(1));
            b_addr = 9'($urandom_range(15)); b_wdata = 16'($urandom);
         end
         cycle();
      end
   endtask

   initial begin
      resetl = 1'b0;
      a_req = 1'b1; a_rw = 1'b1; a_addr = 9'd0; a_wdata = 16'h0000;
      b_req = 1'b1; b_rw = 1'b1; b_addr = 9'd0; b_wdata = 16'h0000;
      repeat (3) cycle();
      resetl = 1'b1;
      repeat (200) cycle();
      resetl = 1'b0;
      repeat (2) cycle();
      resetl = 1'b1;
      repeat (512) cycle();
      a_req = 1'b0; b_req = 1'b0;
      cycle();

      a_req = 1'b1; a_rw = 1'b0; a_addr = 9'h005; a_wdata = 16'h1234;
      cycle();
      a_rw = 1'b1;
      cycle();
      a_req = 1'b0;
      cycle();
      check_val("rd_hold", a_rdata, 16'h1234);

      a_got = 1'b1; b_got = 1'b1;
      rand_cycles(20, 100, 1'b1);
      rand_cycles(2000, 60, 1'b0);
      rand_cycles(12, 100, 1'b0);
      a_req = 1'b0;
      rand_cycles(4, 100, 1'b0);

      a_req = 1'b1; a_rw = 1'b1; a_addr = 9'h003; b_req = 1'b0;
      cycle();
      resetl = 1'b0; a_req = 1'b0;
      repeat (2) cycle();
      resetl = 1'b1;
      repeat (513) cycle();
      rand_cycles(300, 70, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
